// File: rtl/mima_pkg.sv
// Shared constants and types for the integer writeback path.
package mima_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int NUM_SRC  = 3;

  // Source indices into the writeback request vectors.
  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_MDU = 2;

  // One writeback result: destination register and value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter: grants the first valid requester after the last winner.
// The pointer holds the most recently granted index; the scan starts one past it
// and wraps explicitly, so N need not be a power of two.
module rr_arbiter #(
  parameter int N = 3,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  logic [W-1:0] ptr_q;

  // Combinational scan ptr+1, ptr+2, ... modulo N; first valid wins.
  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = W'(idx);
        found      = 1'b1;
      end
    end
  end

  // Pointer follows the winner; reset points at N-1 so index 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= W'(N - 1);
    end else if (|grant) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin selection of execution results into a single
// registered register-file write port, plus a pending-write scoreboard for decode.
//
// Handshake: a source result transfers in the cycle where src_valid[i] and
// src_ready[i] are both high. src_ready is a pure function of src_valid and the
// round-robin pointer (never of data/rd), at most one bit is high, and a source
// must hold valid/rd/data stable until it sees ready.
module wb_arbiter #(
  parameter int NSRC = mima_pkg::NUM_SRC,
  parameter int XLEN = mima_pkg::XLEN,
  parameter int AW   = mima_pkg::REG_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      src_valid,
  output logic [NSRC-1:0]      src_ready,
  input  logic [NSRC*AW-1:0]   src_rd,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata
);

  localparam int NREG = 1 << AW;
  localparam int IW   = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            accept;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  rr_arbiter #(.N(NSRC)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid     (src_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign src_ready = grant;
  assign accept    = |grant;

  // Select the winning source's destination and data.
  always_comb begin
    sel_rd   = src_rd[grant_idx*AW +: AW];
    sel_data = src_data[grant_idx*XLEN +: XLEN];
  end

  // Write stage: one-cycle registered write; x0 results are consumed without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (accept) begin
      rf_wen   <= (sel_rd != '0);
      rf_waddr <= sel_rd;
      rf_wdata <= sel_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // Scoreboard next state: clear on accepted result, then set on issue so that
  // a same-cycle issue to the same register keeps it busy. x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (accept && (sel_rd != '0)) busy_d[sel_rd] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Busy lookup reads the registered bits only: no same-cycle bypass.
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of grants, writes and busy bits.
module tb_wb_arbiter;
  import mima_pkg::*;

  localparam int N  = 3;
  localparam int XW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*AW-1:0] src_rd;
  logic [N*XW-1:0] src_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd, rs1, rs2;
  logic            rs1_busy, rs2_busy, rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XW-1:0]   rf_wdata;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int          m_last;
  bit          m_busy [32];
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          last_grant;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd), .src_data(src_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input bit v, input logic [4:0] rd, input logic [31:0] d);
    src_valid[i]          = v;
    src_rd[i*AW +: AW]    = rd;
    src_data[i*XW +: XW]  = d;
  endtask

  task automatic model_reset();
    m_last  = N - 1;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    foreach (m_busy[r]) m_busy[r] = 1'b0;
  endtask

  // One clock: entered at negedge with inputs driven; checks outputs against the
  // model, advances the model across the posedge, returns at the next negedge.
  task automatic cycle();
    int          g;
    int          idx;
    logic [4:0]  grd;
    logic [31:0] gd;
    logic [2:0]  exp_ready;
    #1;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (g < 0 && src_valid[idx]) g = idx;
    end
    exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
    check("src_ready", src_ready, exp_ready);
    check("rs1_busy", rs1_busy, m_busy[rs1]);
    check("rs2_busy", rs2_busy, m_busy[rs2]);
    check("rf_wen", rf_wen, m_wen);
    check("rf_waddr", rf_waddr, m_waddr);
    check("rf_wdata", rf_wdata, m_wdata);
    last_grant = g;
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        grd     = src_rd[g*AW +: AW];
        gd      = src_data[g*XW +: XW];
        m_wen   = (grd != 0);
        m_waddr = grd;
        m_wdata = gd;
        m_last  = g;
        if (grd != 0) m_busy[grd] = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; src_rd = '0; src_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;

    // 1: reset held two cycles.
    repeat (2) @(negedge clk);
    model_reset();
    check("rst_wen", rf_wen, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r); rs2 = 5'(31 - r);
      #1;
      check("rst_rs1_busy", rs1_busy, 0);
      check("rst_rs2_busy", rs2_busy, 0);
    end
    rst = 1'b0; rs1 = '0; rs2 = '0;
    cycle();

    // 2: single ALU source.
    set_src(SRC_ALU, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    check("t2_grant", last_grant, SRC_ALU);
    set_src(SRC_ALU, 1'b0, 5'd0, 32'h0);
    check("t2_wen", rf_wen, 1);
    check("t2_waddr", rf_waddr, 5);
    check("t2_wdata", rf_wdata, 32'hDEADBEEF);
    cycle();
    check("t2_wen_drop", rf_wen, 0);
    check("t2_waddr_hold", rf_waddr, 5);

    // 3: contention from reset, all sources valid every cycle.
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(i + 1), 32'hA000_0000 + i);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("t3_grant", last_grant, k % 3);
      check("t3_waddr", rf_waddr, (k % 3) + 1);
    end
    src_valid = '0;
    cycle();

    // 4: scoreboard set / clear / same-cycle set wins.
    rs1 = 5'd7; iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    iss_valid = 1'b0;
    check("t4_busy_set", rs1_busy, 1);
    set_src(SRC_LSU, 1'b1, 5'd7, 32'h7777);
    cycle();
    set_src(SRC_LSU, 1'b0, 5'd0, 32'h0);
    check("t4_busy_clr", rs1_busy, 0);
    iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    set_src(SRC_LSU, 1'b1, 5'd7, 32'h7778);
    cycle();
    iss_valid = 1'b0;
    set_src(SRC_LSU, 1'b0, 5'd0, 32'h0);
    check("t4_set_wins", rs1_busy, 1);
    set_src(SRC_LSU, 1'b1, 5'd7, 32'h7779);
    cycle();
    set_src(SRC_LSU, 1'b0, 5'd0, 32'h0);

    // 5: x0 results and x0 issue.
    set_src(SRC_MDU, 1'b1, 5'd0, 32'h1234);
    cycle();
    check("t5_grant", last_grant, SRC_MDU);
    set_src(SRC_MDU, 1'b0, 5'd0, 32'h0);
    check("t5_wen", rf_wen, 0);
    rs1 = 5'd0; iss_valid = 1'b1; iss_rd = 5'd0;
    cycle();
    iss_valid = 1'b0;
    check("t5_x0_busy", rs1_busy, 0);

    // 6: reset on the same edge as an accept.
    rs1 = 5'd9; iss_valid = 1'b1; iss_rd = 5'd9;
    cycle();
    iss_valid = 1'b0;
    check("t6_busy_pre", rs1_busy, 1);
    set_src(SRC_LSU, 1'b1, 5'd9, 32'h9999);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_src(SRC_LSU, 1'b0, 5'd0, 32'h0);
    check("t6_wen", rf_wen, 0);
    check("t6_busy", rs1_busy, 0);
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(10 + i), 32'hB0 + i);
    cycle();
    check("t6_first_grant", last_grant, 0);
    src_valid = '0;
    cycle();

    // Randomized traffic: sources hold until accepted, random issues and queries.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!src_valid[i] && $urandom_range(0, 2) == 0)
          set_src(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom_range(0, 31));
      rs1       = 5'($urandom_range(0, 31));
      rs2       = 5'($urandom_range(0, 31));
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
      if (last_grant >= 0) src_valid[last_grant] = 1'b0;
    end
    rst = 1'b0; src_valid = '0; iss_valid = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
